// File: rtl/timing_pipe_sched_if.sv
// timing_pipe_sched_if: requester-side handshake and response bus of the scheduler
interface timing_pipe_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*DATA_W-1:0] req_c;
  logic [NUM_REQ*DATA_W-1:0] req_d;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [2*DATA_W-1:0]       rsp_y;
  modport master (
    output req_valid, req_a, req_b, req_c, req_d,
    input  req_ready, rsp_valid, rsp_y
  );
  modport slave (
    input  req_valid, req_a, req_b, req_c, req_d,
    output req_ready, rsp_valid, rsp_y
  );
endinterface

// File: rtl/timing_pipe_sched.sv
// timing_pipe_sched: round-robin scheduler sharing one pipelined datapath between requesters
// Optional performance counters are enabled by defining PIPE_SCHED_PERF_EN.
module timing_pipe_sched #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 16,
  parameter int PIPE_LAT = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_en,
  timing_pipe_sched_if.slave  req,
  output logic [DATA_W-1:0]   pipe_a,
  output logic [DATA_W-1:0]   pipe_b,
  output logic [DATA_W-1:0]   pipe_c,
  output logic [DATA_W-1:0]   pipe_d,
  input  logic [2*DATA_W-1:0] pipe_y,
  output logic                idle
`ifdef PIPE_SCHED_PERF_EN
  ,
  output logic [31:0]         perf_issued,
  output logic [31:0]         perf_stalled,
  output logic [3:0]          perf_max_busy
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  logic [DATA_W-1:0]    op_a [NUM_REQ];
  logic [DATA_W-1:0]    op_b [NUM_REQ];
  logic [DATA_W-1:0]    op_c [NUM_REQ];
  logic [DATA_W-1:0]    op_d [NUM_REQ];
  logic [IW-1:0]        rr_ptr;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IW-1:0]        off;
  logic [IW:0]          sum;
  logic [IW-1:0]        win;
  logic                 found;
  logic                 accept;
  logic [PIPE_LAT:0]    tag_v;
  logic [IW-1:0]        tag_i [PIPE_LAT+1];
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [2*DATA_W-1:0]  rsp_y_q;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ops
    assign op_a[i] = req.req_a[i*DATA_W +: DATA_W];
    assign op_b[i] = req.req_b[i*DATA_W +: DATA_W];
    assign op_c[i] = req.req_c[i*DATA_W +: DATA_W];
    assign op_d[i] = req.req_d[i*DATA_W +: DATA_W];
  end
  assign dbl   = {req.req_valid, req.req_valid} >> rr_ptr;
  assign rot   = dbl[NUM_REQ-1:0];
  assign found = |req.req_valid;
  // first valid requester at or after rr_ptr, as an offset from rr_ptr
  always_comb begin
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) off = rot[IW'(k)] ? IW'(k) : off;
  end
  assign sum           = {1'b0, rr_ptr} + {1'b0, off};
  assign win           = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : sum[IW-1:0];
  assign accept        = found & issue_en & ~rst;
  assign req.req_ready = accept ? NUM_REQ'(1) << win : '0;
  assign req.rsp_valid = rsp_valid_q;
  assign req.rsp_y     = rsp_y_q;
  assign idle          = ~|tag_v & ~|rsp_valid_q & (~issue_en | ~found);
  // issue stage: operands and pointer only move on an accept
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_a <= '0;
      pipe_b <= '0;
      pipe_c <= '0;
      pipe_d <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      pipe_a <= op_a[win];
      pipe_b <= op_b[win];
      pipe_c <= op_c[win];
      pipe_d <= op_d[win];
      rr_ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
    end
  end
  // tag stage 0 sits beside the issue registers; the last stage lines up with pipe_y
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      tag_i <= '{default: '0};
    end else begin
      tag_v    <= {tag_v[PIPE_LAT-1:0], accept};
      tag_i[0] <= win;
      for (int k = 1; k <= PIPE_LAT; k++) tag_i[k] <= tag_i[k-1];
    end
  end
  // response register: strobe the owner and capture the datapath result
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_y_q     <= '0;
    end else begin
      rsp_valid_q <= tag_v[PIPE_LAT] ? NUM_REQ'(1) << tag_i[PIPE_LAT] : '0;
      rsp_y_q     <= tag_v[PIPE_LAT] ? pipe_y : rsp_y_q;
    end
  end
`ifdef PIPE_SCHED_PERF_EN
  logic [3:0] busy;
  assign busy = 4'($countones(tag_v));
  // saturating activity counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued   <= '0;
      perf_stalled  <= '0;
      perf_max_busy <= '0;
    end else begin
      perf_issued   <= perf_issued + 32'(accept && !(&perf_issued));
      perf_stalled  <= perf_stalled + 32'(found && !accept && !(&perf_stalled));
      perf_max_busy <= (busy > perf_max_busy) ? busy : perf_max_busy;
    end
  end
`endif
endmodule

// File: tb/tb_timing_pipe_sched.sv
// tb_timing_pipe_sched: directed self-checking bench with a behavioural 5-stage datapath
module tb_timing_pipe_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_en = 1'b1;
  logic [15:0] pipe_a, pipe_b, pipe_c, pipe_d;
  logic [31:0] pipe_y = '0;
  logic        idle;
  logic [31:0] s1 = '0, s2 = '0, s3 = '0, s4 = '0;
  int          checks = 0;
  int          passed = 0;
  bit          bad;
  logic [31:0] exp_rr [4] = '{32'd25, 32'd55, 32'd95, 32'd145};
`ifdef PIPE_SCHED_PERF_EN
  logic [31:0] perf_issued, perf_stalled;
  logic [3:0]  perf_max_busy;
`endif
  timing_pipe_sched_if #(.NUM_REQ(4), .DATA_W(16)) sif ();
  timing_pipe_sched #(.NUM_REQ(4), .DATA_W(16), .PIPE_LAT(5)) dut (
    .clk(clk), .rst(rst), .issue_en(issue_en), .req(sif),
    .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c), .pipe_d(pipe_d),
    .pipe_y(pipe_y), .idle(idle)
`ifdef PIPE_SCHED_PERF_EN
    , .perf_issued(perf_issued), .perf_stalled(perf_stalled), .perf_max_busy(perf_max_busy)
`endif
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) begin
    s1     <= (32'(pipe_a) + 32'(pipe_b)) * (32'(pipe_c) + 32'(pipe_d)) + 32'(pipe_a) * 32'(pipe_d);
    s2     <= s1;
    s3     <= s2;
    s4     <= s3;
    pipe_y <= s4;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_ops(input int i, input logic [15:0] a, b, c, d);
    sif.req_a[i*16 +: 16] = a;
    sif.req_b[i*16 +: 16] = b;
    sif.req_c[i*16 +: 16] = c;
    sif.req_d[i*16 +: 16] = d;
  endtask
  task automatic test_reset();
    sif.req_valid = 4'b0001;
    sif.req_a = '0; sif.req_b = '0; sif.req_c = '0; sif.req_d = '0;
    tick();
    tick();
    checks++; if (sif.req_ready !== 4'b0000) $display("FAIL reset_ready got %b exp %b", sif.req_ready, 4'b0000); else passed++;
    sif.req_valid = '0;
    #1;
    checks++; if (pipe_a !== 16'd0) $display("FAIL reset_pipe_a got %h exp %h", pipe_a, 16'd0); else passed++;
    checks++; if (sif.rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid got %b exp %b", sif.rsp_valid, 4'b0000); else passed++;
    checks++; if (sif.rsp_y !== 32'd0) $display("FAIL reset_rsp_y got %h exp %h", sif.rsp_y, 32'd0); else passed++;
    checks++; if (idle !== 1'b1) $display("FAIL reset_idle got %b exp %b", idle, 1'b1); else passed++;
    rst = 1'b0;
    tick();
  endtask
  task automatic test_single();
    set_ops(0, 16'd1, 16'd2, 16'd3, 16'd4);
    sif.req_valid = 4'b0001;
    #1;
    checks++; if (sif.req_ready !== 4'b0001) $display("FAIL single_ready got %b exp %b", sif.req_ready, 4'b0001); else passed++;
    tick();
    sif.req_valid = '0;
    checks++; if (pipe_a !== 16'd1) $display("FAIL single_pipe_a got %h exp %h", pipe_a, 16'd1); else passed++;
    bad = 0;
    repeat (5) begin tick(); if (sif.rsp_valid !== 4'b0000) bad = 1; end
    checks++; if (bad) $display("FAIL single_early got %b exp %b", bad, 1'b0); else passed++;
    tick();
    checks++; if (sif.rsp_valid !== 4'b0001) $display("FAIL single_rsp_valid got %b exp %b", sif.rsp_valid, 4'b0001); else passed++;
    checks++; if (sif.rsp_y !== 32'd25) $display("FAIL single_rsp_y got %h exp %h", sif.rsp_y, 32'd25); else passed++;
    tick();
    tick();
    checks++; if (idle !== 1'b1) $display("FAIL single_idle got %b exp %b", idle, 1'b1); else passed++;
  endtask
  task automatic test_full_scale();
    set_ops(2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    sif.req_valid = 4'b0100;
    #1;
    checks++; if (sif.req_ready !== 4'b0100) $display("FAIL full_ready got %b exp %b", sif.req_ready, 4'b0100); else passed++;
    tick();
    sif.req_valid = '0;
    repeat (5) tick();
    tick();
    checks++; if (sif.rsp_valid !== 4'b0100) $display("FAIL full_rsp_valid got %b exp %b", sif.rsp_valid, 4'b0100); else passed++;
    checks++; if (sif.rsp_y !== 32'hFFF60005) $display("FAIL full_rsp_y got %h exp %h", sif.rsp_y, 32'hFFF60005); else passed++;
  endtask
  task automatic test_back_to_back();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_ops(i, 16'(i + 1), 16'(i + 2), 16'(i + 3), 16'(i + 4));
    sif.req_valid = 4'b1111;
    for (int k = 0; k < 14; k++) begin
      if (k == 8) sif.req_valid = '0;
      #1;
      if (k < 8) begin
        checks++; if (sif.req_ready !== 4'(1 << (k % 4))) $display("FAIL rr_ready[%0d] got %b exp %b", k, sif.req_ready, 4'(1 << (k % 4))); else passed++;
      end
      tick();
      if (k >= 6) begin
        checks++; if (sif.rsp_valid !== 4'(1 << ((k - 6) % 4))) $display("FAIL rr_rsp_valid[%0d] got %b exp %b", k, sif.rsp_valid, 4'(1 << ((k - 6) % 4))); else passed++;
        checks++; if (sif.rsp_y !== exp_rr[(k - 6) % 4]) $display("FAIL rr_rsp_y[%0d] got %h exp %h", k, sif.rsp_y, exp_rr[(k - 6) % 4]); else passed++;
      end else begin
        checks++; if (sif.rsp_valid !== 4'b0000) $display("FAIL rr_early[%0d] got %b exp %b", k, sif.rsp_valid, 4'b0000); else passed++;
      end
    end
  endtask
  task automatic test_fairness();
    logic [3:0] seq [3] = '{4'b1000, 4'b0010, 4'b1000};
    sif.req_valid = 4'b0010;
    #1;
    checks++; if (sif.req_ready !== 4'b0010) $display("FAIL fair_setup got %b exp %b", sif.req_ready, 4'b0010); else passed++;
    tick();
    sif.req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (sif.req_ready !== seq[k]) $display("FAIL fair_ready[%0d] got %b exp %b", k, sif.req_ready, seq[k]); else passed++;
      tick();
    end
    sif.req_valid = '0;
    repeat (8) tick();
    checks++; if (idle !== 1'b1) $display("FAIL fair_idle got %b exp %b", idle, 1'b1); else passed++;
  endtask
  task automatic test_reset_midflight();
    set_ops(0, 16'd5, 16'd6, 16'd7, 16'd8);
    sif.req_valid = 4'b0001;
    repeat (3) tick();
    sif.req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++; if (sif.rsp_valid !== 4'b0000) $display("FAIL mid_rsp_valid got %b exp %b", sif.rsp_valid, 4'b0000); else passed++;
    checks++; if (sif.rsp_y !== 32'd0) $display("FAIL mid_rsp_y got %h exp %h", sif.rsp_y, 32'd0); else passed++;
    checks++; if (pipe_a !== 16'd0) $display("FAIL mid_pipe_a got %h exp %h", pipe_a, 16'd0); else passed++;
    checks++; if (idle !== 1'b1) $display("FAIL mid_idle got %b exp %b", idle, 1'b1); else passed++;
    rst = 1'b0;
    bad = 0;
    repeat (8) begin tick(); if (sif.rsp_valid !== 4'b0000) bad = 1; end
    checks++; if (bad) $display("FAIL mid_ghost_rsp got %b exp %b", bad, 1'b0); else passed++;
    set_ops(3, 16'd3, 16'd0, 16'd0, 16'd7);
    sif.req_valid = 4'b1000;
    #1;
    checks++; if (sif.req_ready !== 4'b1000) $display("FAIL mid_new_ready got %b exp %b", sif.req_ready, 4'b1000); else passed++;
    tick();
    sif.req_valid = '0;
    bad = 0;
    repeat (5) begin tick(); if (sif.rsp_valid !== 4'b0000) bad = 1; end
    checks++; if (bad) $display("FAIL mid_new_early got %b exp %b", bad, 1'b0); else passed++;
    tick();
    checks++; if (sif.rsp_valid !== 4'b1000) $display("FAIL mid_new_rsp_valid got %b exp %b", sif.rsp_valid, 4'b1000); else passed++;
    checks++; if (sif.rsp_y !== 32'd42) $display("FAIL mid_new_rsp_y got %h exp %h", sif.rsp_y, 32'd42); else passed++;
  endtask
  task automatic test_drain();
    set_ops(0, 16'd1, 16'd2, 16'd3, 16'd4);
    set_ops(1, 16'd9, 16'd1, 16'd1, 16'd2);
    set_ops(2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    sif.req_valid = 4'b0101;
    #1;
    checks++; if (sif.req_ready !== 4'b0001) $display("FAIL drain_grant0 got %b exp %b", sif.req_ready, 4'b0001); else passed++;
    tick();
    checks++; if (sif.req_ready !== 4'b0100) $display("FAIL drain_grant2 got %b exp %b", sif.req_ready, 4'b0100); else passed++;
    tick();
    sif.req_valid = 4'b0010;
    issue_en = 1'b0;
    #1;
    checks++; if (sif.req_ready !== 4'b0000) $display("FAIL drain_ready got %b exp %b", sif.req_ready, 4'b0000); else passed++;
    checks++; if (idle !== 1'b0) $display("FAIL drain_busy got %b exp %b", idle, 1'b0); else passed++;
    bad = 0;
    for (int k = 2; k <= 8; k++) begin
      tick();
      if (sif.req_ready !== 4'b0000) bad = 1;
      if (k == 6) begin
        checks++; if (sif.rsp_valid !== 4'b0001) $display("FAIL drain_rsp0_valid got %b exp %b", sif.rsp_valid, 4'b0001); else passed++;
        checks++; if (sif.rsp_y !== 32'd25) $display("FAIL drain_rsp0_y got %h exp %h", sif.rsp_y, 32'd25); else passed++;
      end
      if (k == 7) begin
        checks++; if (sif.rsp_valid !== 4'b0100) $display("FAIL drain_rsp2_valid got %b exp %b", sif.rsp_valid, 4'b0100); else passed++;
        checks++; if (sif.rsp_y !== 32'hFFF60005) $display("FAIL drain_rsp2_y got %h exp %h", sif.rsp_y, 32'hFFF60005); else passed++;
        checks++; if (idle !== 1'b0) $display("FAIL drain_rsp_pending_idle got %b exp %b", idle, 1'b0); else passed++;
      end
      if (k == 8) begin
        checks++; if (idle !== 1'b1) $display("FAIL drain_idle got %b exp %b", idle, 1'b1); else passed++;
      end
    end
    checks++; if (bad) $display("FAIL drain_no_grant got %b exp %b", bad, 1'b0); else passed++;
    issue_en = 1'b1;
    #1;
    checks++; if (sif.req_ready !== 4'b0010) $display("FAIL drain_resume_ready got %b exp %b", sif.req_ready, 4'b0010); else passed++;
    checks++; if (idle !== 1'b0) $display("FAIL drain_resume_idle got %b exp %b", idle, 1'b0); else passed++;
    tick();
    sif.req_valid = '0;
    checks++; if (pipe_a !== 16'd9) $display("FAIL drain_resume_pipe_a got %h exp %h", pipe_a, 16'd9); else passed++;
    repeat (6) tick();
    checks++; if (sif.rsp_valid !== 4'b0010) $display("FAIL drain_resume_rsp got %b exp %b", sif.rsp_valid, 4'b0010); else passed++;
    checks++; if (sif.rsp_y !== 32'd48) $display("FAIL drain_resume_y got %h exp %h", sif.rsp_y, 32'd48); else passed++;
  endtask
`ifdef PIPE_SCHED_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sif.req_valid = 4'b0001;
    tick();
    tick();
    issue_en = 1'b0;
    tick();
    sif.req_valid = '0;
    issue_en = 1'b1;
    tick();
    checks++; if (perf_issued !== 32'd2) $display("FAIL perf_issued got %0d exp %0d", perf_issued, 2); else passed++;
    checks++; if (perf_stalled !== 32'd1) $display("FAIL perf_stalled got %0d exp %0d", perf_stalled, 1); else passed++;
    checks++; if (perf_max_busy !== 4'd2) $display("FAIL perf_max_busy got %0d exp %0d", perf_max_busy, 2); else passed++;
    repeat (8) tick();
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_full_scale();
    test_back_to_back();
    test_fairness();
    test_reset_midflight();
    test_drain();
`ifdef PIPE_SCHED_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
